// File: rtl/disparity_pkg.sv
// Shared types and constants for the disparity pacer.
//   state_t       : pacer FSM states
//   DEF_*         : default configuration constants
//   addr_width    : result BRAM address width for a given depth
//   count_width   : width able to hold 0..depth
//   sum_width     : accumulator width that cannot overflow for depth words
package disparity_pkg;

  localparam int unsigned DEF_RESULT_DEPTH   = 1280;
  localparam int unsigned DEF_DISP_W         = 8;
  localparam int unsigned DEF_READ_LATENCY   = 2;
  localparam int unsigned DEF_MIN_VALID_DISP = 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    DIVIDE,
    DONE
  } state_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned sum_width(input int unsigned depth, input int unsigned disp_w);
    return disp_w + $clog2(depth);
  endfunction

endpackage

// File: rtl/disparity_pacer_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// The start cycle already performs the first iteration, so the quotient is
// final WIDTH edges after start is sampled; done pulses in that same cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle request; dividend/divisor sampled with it
//   dividend   : WIDTH-bit numerator
//   divisor    : WIDTH-bit denominator (zero gives an all-ones quotient)
//   busy       : iterations still pending
//   done       : one-cycle pulse, quotient is final
//   quotient   : WIDTH-bit result
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] r_in, q_in, d_in;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH:0]   trial;
  logic [CNT_W-1:0] cnt_q;

  // On start the step runs on freshly loaded operands instead of the registers.
  always_comb begin
    r_in  = start ? '0 : rem_q;
    q_in  = start ? dividend : quo_q;
    d_in  = start ? divisor : dvs_q;
    trial = {r_in, q_in[WIDTH-1]};
    if (trial >= {1'b0, d_in}) begin
      rem_nxt = trial[WIDTH-1:0] - d_in;
      quo_nxt = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {q_in[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(WIDTH - 1);
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/disparity_pacer.sv
// Sweeps the stereo matcher's SSD result BRAM after each frame, accumulates
// max / sum / count of valid disparities, divides for the mean and maps the
// mean's top nibble to the LED pace speed.
// Optional macro DISPARITY_PACER_SMOOTH_EN: exponentially smoothed speed_out.
// Ports:
//   clk_in, rst_in     : clock, asynchronous active-high reset
//   frame_done_in      : matcher results ready (one-cycle pulse)
//   ssd_addr_out       : result BRAM read address
//   ssd_rd_en_out      : result BRAM read enable
//   ssd_din            : result BRAM read data
//   busy_out           : frame being processed
//   result_valid_out   : one-cycle pulse, result outputs updated
//   max_disp_out       : largest valid disparity
//   mean_disp_out      : floor(sum / count), 0 when no valid entries
//   valid_count_out    : number of valid entries
//   speed_out          : pace speed for led_top, held between frames
//   overrun_out        : sticky, frame_done_in seen while busy
module disparity_pacer
  import disparity_pkg::*;
#(
  parameter int unsigned RESULT_DEPTH   = DEF_RESULT_DEPTH,
  parameter int unsigned DISP_W         = DEF_DISP_W,
  parameter int unsigned READ_LATENCY   = DEF_READ_LATENCY,
  parameter int unsigned MIN_VALID_DISP = DEF_MIN_VALID_DISP
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 frame_done_in,
  output logic [addr_width(RESULT_DEPTH)-1:0]  ssd_addr_out,
  output logic                                 ssd_rd_en_out,
  input  logic [DISP_W-1:0]                    ssd_din,
  output logic                                 busy_out,
  output logic                                 result_valid_out,
  output logic [DISP_W-1:0]                    max_disp_out,
  output logic [DISP_W-1:0]                    mean_disp_out,
  output logic [count_width(RESULT_DEPTH)-1:0] valid_count_out,
  output logic [3:0]                           speed_out,
  output logic                                 overrun_out
);

  localparam int unsigned AW    = addr_width(RESULT_DEPTH);
  localparam int unsigned CW    = count_width(RESULT_DEPTH);
  localparam int unsigned SUM_W = sum_width(RESULT_DEPTH, DISP_W);
  localparam int unsigned DCW   = $clog2(READ_LATENCY + 1);

  state_t                  state;
  logic [READ_LATENCY-1:0] vld, vld_nxt;
  logic [SUM_W-1:0]        sum_q, sum_nxt;
  logic [CW-1:0]           cnt_q, cnt_nxt;
  logic [DISP_W-1:0]       max_q, max_nxt;
  logic [DISP_W-1:0]       mean_q;
  logic [DCW-1:0]          drain_cnt;
  logic                    hit, drain_last;
  logic                    div_start, div_busy, div_done;
  logic [SUM_W-1:0]        div_quo;
  logic [DISP_W-1:0]       quo_sat;
  logic [3:0]              raw_speed;

  // The last in-flight word lands on the edge that leaves DRAIN, so the
  // zero-count decision and the divider operands use the post-update values.
  always_comb begin
    vld_nxt    = vld << 1;
    vld_nxt[0] = ssd_rd_en_out;
    hit        = vld[READ_LATENCY-1] && (ssd_din >= DISP_W'(MIN_VALID_DISP));
    sum_nxt    = sum_q;
    cnt_nxt    = cnt_q;
    max_nxt    = max_q;
    if (hit) begin
      sum_nxt = sum_q + SUM_W'(ssd_din);
      cnt_nxt = cnt_q + CW'(1);
      if (ssd_din > max_q) max_nxt = ssd_din;
    end
    drain_last = (state == DRAIN) && (drain_cnt == DCW'(READ_LATENCY - 1));
    div_start  = drain_last && (cnt_nxt != '0);
    quo_sat    = (|div_quo[SUM_W-1:DISP_W]) ? '1 : div_quo[DISP_W-1:0];
    raw_speed  = mean_q[DISP_W-1 -: 4];
  end

  seq_divider #(
    .WIDTH(SUM_W)
  ) u_div (
    .clk      (clk_in),
    .rst      (rst_in),
    .start    (div_start),
    .dividend (sum_nxt),
    .divisor  (SUM_W'(cnt_nxt)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      vld              <= '0;
      sum_q            <= '0;
      cnt_q            <= '0;
      max_q            <= '0;
      mean_q           <= '0;
      drain_cnt        <= '0;
      ssd_addr_out     <= '0;
      ssd_rd_en_out    <= 1'b0;
      busy_out         <= 1'b0;
      result_valid_out <= 1'b0;
      max_disp_out     <= '0;
      mean_disp_out    <= '0;
      valid_count_out  <= '0;
      overrun_out      <= 1'b0;
    end else begin
      result_valid_out <= 1'b0;
      vld              <= vld_nxt;
      if (frame_done_in && busy_out) overrun_out <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_done_in) begin
            sum_q         <= '0;
            cnt_q         <= '0;
            max_q         <= '0;
            mean_q        <= '0;
            ssd_addr_out  <= '0;
            ssd_rd_en_out <= 1'b1;
            busy_out      <= 1'b1;
            state         <= SCAN;
          end
        end
        SCAN: begin
          sum_q <= sum_nxt;
          cnt_q <= cnt_nxt;
          max_q <= max_nxt;
          if (ssd_addr_out == AW'(RESULT_DEPTH - 1)) begin
            ssd_rd_en_out <= 1'b0;
            drain_cnt     <= '0;
            state         <= DRAIN;
          end else begin
            ssd_addr_out <= ssd_addr_out + AW'(1);
          end
        end
        DRAIN: begin
          sum_q <= sum_nxt;
          cnt_q <= cnt_nxt;
          max_q <= max_nxt;
          if (drain_last) begin
            state <= (cnt_nxt == '0) ? DONE : DIVIDE;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        DIVIDE: begin
          if (div_done && !div_busy) begin
            mean_q <= quo_sat;
            state  <= DONE;
          end
        end
        DONE: begin
          max_disp_out     <= max_q;
          mean_disp_out    <= mean_q;
          valid_count_out  <= cnt_q;
          result_valid_out <= 1'b1;
          busy_out         <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPARITY_PACER_SMOOTH_EN
  // 4.2 fixed-point low-pass: s' = s - s/4 + raw, speed = integer part of s/4.
  logic [5:0] smooth_q, smooth_nxt;
  logic       smooth_loaded;

  always_comb begin
    smooth_nxt = smooth_q - (smooth_q >> 2) + {2'b00, raw_speed};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      smooth_q      <= '0;
      smooth_loaded <= 1'b0;
      speed_out     <= '0;
    end else if (state == DONE) begin
      if (!smooth_loaded) begin
        smooth_q      <= {raw_speed, 2'b00};
        smooth_loaded <= 1'b1;
        speed_out     <= raw_speed;
      end else begin
        smooth_q  <= smooth_nxt;
        speed_out <= smooth_nxt[5:2];
      end
    end
  end
`else
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      speed_out <= '0;
    end else if (state == DONE) begin
      speed_out <= raw_speed;
    end
  end
`endif

endmodule
